crc_engine: RTL and testbench
=============================

Name: crc_engine

Overview:
Parametrised CRC generator/checker and next-generation replacement for the fixed 8-bit-in CRC-12 block. It processes one DATA_W-bit word per clock, with polynomial, init, xor-out and bit reflection set by parameters. Frames are delimited by sof/eof. In check mode it compares the final CRC against a reference value. It sits in the transceiver datapath between the framer and the line coder (TX) or deframer (RX).

Parameters:
CRC_W, 12, CRC width in bits (4..32)
POLY, 12'h80F, generator polynomial, implicit x^CRC_W term omitted
INIT, 0, CRC register preset at sof
XOR_OUT, 0, final XOR applied to the output CRC
DATA_W, 8, input word width (1..64)
REFLECT_IN, 0, 1 = process in_data bit 0 first; 0 = MSB first
REFLECT_OUT, 0, 1 = bit-reverse the CRC before XOR_OUT

Ports:
clk  in  1  system clock, rising edge
arstn  in  1  asynchronous active-low reset
in_valid  in  1  input word qualifier; no backpressure, a word is accepted every valid cycle
in_sof  in  1  first word of frame (qualified by in_valid)
in_eof  in  1  last word of frame (qualified by in_valid)
in_data  in  DATA_W  data word
chk_en  in  1  check mode; sampled on the eof beat
crc_ref  in  CRC_W  expected CRC; sampled on the eof beat
crc  out  CRC_W  final CRC of the last completed frame; held until the next completion
crc_valid  out  1  one-cycle pulse when crc updates
crc_ok  out  1  crc == crc_ref when crc_valid and check mode; 0 otherwise
busy  out  1  high while in RUN
err  out  1  one-cycle pulse on protocol error

Behaviour:
- Reset (async assert, sync release): state=IDLE; internal register=INIT; crc=0, crc_valid=0, crc_ok=0, busy=0, err=0.
- State machine: IDLE, RUN.
  - IDLE + valid + sof + !eof -> RUN, reg <= step(INIT, data).
  - IDLE + valid + !sof -> ignored; err pulses next cycle; stays IDLE.
  - RUN + valid + !sof -> reg <= step(reg, data).
  - RUN + valid + sof -> restart: reg <= step(INIT, data); err pulses; stays RUN (or completes, if eof is also set).
  - Any state + valid + eof (frame start or continuation valid) -> IDLE; reg <= INIT.
- Completion on the eof beat: next cycle crc <= fin(step(x, data)), where x = INIT if sof else reg; crc_valid=1 for exactly one cycle.
- fin(v) = (REFLECT_OUT ? bitrev(v) : v) ^ XOR_OUT.
- Latency: eof beat at cycle N -> crc/crc_valid/crc_ok at cycle N+1.
- sof+eof on the same beat is a legal one-word frame.
- Back-to-back frames: a new sof in the cycle after eof is accepted with no bubble.
- in_valid low holds all state; gaps of any length are allowed mid-frame.
- crc_ok = chk_en_s & (fin == crc_ref_s), where _s denotes the value captured on the eof beat; registered alongside crc.
- step(): DATA_W iterations of the MSB-first LFSR.
  - Per iteration: fb = reg[CRC_W-1] ^ d_i; reg = {reg[CRC_W-2:0],0} ^ (fb ? POLY : 0).
  - d_i order is MSB->LSB, or LSB->MSB when REFLECT_IN=1.
  - For REFLECT_IN=1 the engine runs on the reflected polynomial equivalently; the output must match the reference CRC definitions.
- Reset asserted mid-frame aborts the frame; no crc_valid is produced.

Decomposition:
- Package crc_pkg: state enum (IDLE, RUN), bitrev function, and presets as constant sets: CRC12_DECT, CRC16_CCITT_FALSE, CRC32.
- One combinational sub-module crc_step (params CRC_W, POLY, DATA_W, REFLECT_IN): crc_in, data -> crc_out. It is instantiated once.
- FSM and output registers live in crc_engine.

Test Plan:
- Defaults (CRC-12/DECT), DATA_W=8, frame "123456789" (0x31..0x39) -> crc=0xF5B, crc_valid one cycle after the 0x39 beat.
- CRC16_CCITT_FALSE (POLY 0x1021, INIT 0xFFFF), same frame with idle gaps inserted -> crc=0x29B1.
- CRC32 (0x04C11DB7, INIT/XOR_OUT 0xFFFFFFFF, both reflects=1), DATA_W=8, "123456789" -> 0xCBF43926. Repeat with DATA_W=32 packed little-endian plus final byte word.
- Single-word frame sof+eof, data 0x00, defaults -> crc=0x000. The next frame follows the cycle after with no bubble -> both crc_valid pulses present.
- Check mode: chk_en=1, crc_ref=0xF5B -> crc_ok=1; crc_ref=0xF5A -> crc_ok=0. chk_en=0 -> crc_ok=0.
- Protocol errors:
  - valid without sof in IDLE -> err pulse, no crc_valid.
  - sof mid-frame -> err pulse, result equals a fresh frame.
  - arstn low mid-frame -> all outputs 0, no crc_valid.

Source files
------------

// File: rtl/crc_pkg.sv
// Shared types, the bit-reverse helper and common CRC presets for the parametrised CRC engine.
package crc_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  typedef struct packed {
    logic [5:0]  width;
    logic [31:0] poly;
    logic [31:0] init;
    logic [31:0] xor_out;
    logic        refin;
    logic        refout;
  } crc_preset_t;

  localparam crc_preset_t CRC12_DECT = '{
    width: 6'd12, poly: 32'h0000_080F, init: 32'h0, xor_out: 32'h0,
    refin: 1'b0, refout: 1'b0
  };

  localparam crc_preset_t CRC16_CCITT_FALSE = '{
    width: 6'd16, poly: 32'h0000_1021, init: 32'h0000_FFFF, xor_out: 32'h0,
    refin: 1'b0, refout: 1'b0
  };

  localparam crc_preset_t CRC32 = '{
    width: 6'd32, poly: 32'h04C1_1DB7, init: 32'hFFFF_FFFF, xor_out: 32'hFFFF_FFFF,
    refin: 1'b1, refout: 1'b1
  };

  // Reverses the low w bits of v; bits at and above w come back as zero.
  function automatic logic [31:0] bitrev(input logic [31:0] v, input int w);
    logic [31:0] r;
    logic [31:0] s;
    r = '0;
    s = v;
    for (int i = 0; i < 32; i++) begin
      if (i < w) begin
        r = {r[30:0], s[0]};
        s = s >> 1;
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/crc_step.sv
// One clock's worth of CRC update: DATA_W iterations of the MSB-first LFSR, fully unrolled.
module crc_step #(
  parameter int                CRC_W      = 12,
  parameter logic [CRC_W-1:0]  POLY       = CRC_W'(12'h80F),
  parameter int                DATA_W     = 8,
  parameter bit                REFLECT_IN = 1'b0
) (
  input  logic [CRC_W-1:0]  crc_in,
  input  logic [DATA_W-1:0] data,
  output logic [CRC_W-1:0]  crc_out
);

  logic [CRC_W-1:0]  acc;
  logic [DATA_W-1:0] sh;
  logic              d;
  logic              fb;

  // Feeding data LSB-first into the MSB-first register gives the reflected-input CRC
  // once the result is bit-reversed on the way out.
  always_comb begin
    acc = crc_in;
    sh  = data;
    d   = 1'b0;
    fb  = 1'b0;
    for (int i = 0; i < DATA_W; i++) begin
      d   = REFLECT_IN ? sh[0] : sh[DATA_W-1];
      fb  = acc[CRC_W-1] ^ d;
      acc = {acc[CRC_W-2:0], 1'b0} ^ (fb ? POLY : '0);
      sh  = REFLECT_IN ? (sh >> 1) : (sh << 1);
    end
    crc_out = acc;
  end

endmodule

// File: rtl/crc_engine.sv
// Framed CRC generator/checker: one DATA_W word per cycle, sof/eof delimited, optional compare.
module crc_engine
  import crc_pkg::*;
#(
  parameter int                CRC_W       = 12,
  parameter logic [CRC_W-1:0]  POLY        = CRC_W'(12'h80F),
  parameter logic [CRC_W-1:0]  INIT        = '0,
  parameter logic [CRC_W-1:0]  XOR_OUT     = '0,
  parameter int                DATA_W      = 8,
  parameter bit                REFLECT_IN  = 1'b0,
  parameter bit                REFLECT_OUT = 1'b0
) (
  input  logic              clk,
  input  logic              arstn,
  input  logic              in_valid,
  input  logic              in_sof,
  input  logic              in_eof,
  input  logic [DATA_W-1:0] in_data,
  input  logic              chk_en,
  input  logic [CRC_W-1:0]  crc_ref,
  output logic [CRC_W-1:0]  crc,
  output logic              crc_valid,
  output logic              crc_ok,
  output logic              busy,
  output logic              err
);

  state_t           state, state_nx;
  logic [CRC_W-1:0] reg_q, reg_nx;
  logic [CRC_W-1:0] step_in, step_out, fin_val, crc_nx;
  logic             crc_valid_nx, crc_ok_nx, err_nx;

  // A sof always restarts from INIT, whatever state the frame was in.
  assign step_in = (in_sof || state == IDLE) ? INIT : reg_q;

  crc_step #(
    .CRC_W      (CRC_W),
    .POLY       (POLY),
    .DATA_W     (DATA_W),
    .REFLECT_IN (REFLECT_IN)
  ) u_step (
    .crc_in  (step_in),
    .data    (in_data),
    .crc_out (step_out)
  );

  assign fin_val = (REFLECT_OUT ? CRC_W'(bitrev(32'(step_out), CRC_W)) : step_out) ^ XOR_OUT;
  assign busy    = (state == RUN);

  always_comb begin
    state_nx     = state;
    reg_nx       = reg_q;
    crc_nx       = crc;
    crc_valid_nx = 1'b0;
    crc_ok_nx    = 1'b0;
    err_nx       = 1'b0;
    if (in_valid) begin
      if (state == IDLE && !in_sof) begin
        err_nx = 1'b1;
      end else begin
        err_nx = (state == RUN) && in_sof;
        if (in_eof) begin
          state_nx     = IDLE;
          reg_nx       = INIT;
          crc_nx       = fin_val;
          crc_valid_nx = 1'b1;
          crc_ok_nx    = chk_en && (fin_val == crc_ref);
        end else begin
          state_nx = RUN;
          reg_nx   = step_out;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge arstn) begin
    if (!arstn) begin
      state     <= IDLE;
      reg_q     <= INIT;
      crc       <= '0;
      crc_valid <= 1'b0;
      crc_ok    <= 1'b0;
      err       <= 1'b0;
    end else begin
      state     <= state_nx;
      reg_q     <= reg_nx;
      crc       <= crc_nx;
      crc_valid <= crc_valid_nx;
      crc_ok    <= crc_ok_nx;
      err       <= err_nx;
    end
  end

endmodule

// File: tb/tb_crc_engine.sv
// Directed bench for crc_engine: CRC-12/DECT, CRC-16/CCITT-FALSE and CRC-32 (8- and 32-bit words).
module tb_crc_engine;
  import crc_pkg::*;

  logic        clk = 1'b0;
  logic        arstn = 1'b0;
  logic        in_valid = 1'b0, in_sof = 1'b0, in_eof = 1'b0;
  logic [7:0]  in_data = '0;
  logic        chk_en = 1'b0;
  logic [11:0] ref12 = '0;
  logic [15:0] ref16 = '0;
  logic [31:0] ref32 = '0;
  logic        v_w = 1'b0, sof_w = 1'b0, eof_w = 1'b0;
  logic [31:0] data_w = '0;

  logic [11:0] crc12;
  logic [15:0] crc16;
  logic [31:0] crc32a, crc32w;
  logic        val12, ok12, busy12, err12;
  logic        val16, ok16, busy16, err16;
  logic        val32a, ok32a, busy32a, err32a;
  logic        val32w, ok32w, busy32w, err32w;

  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  crc_engine u12 (
    .clk(clk), .arstn(arstn), .in_valid(in_valid), .in_sof(in_sof), .in_eof(in_eof),
    .in_data(in_data), .chk_en(chk_en), .crc_ref(ref12), .crc(crc12), .crc_valid(val12),
    .crc_ok(ok12), .busy(busy12), .err(err12)
  );

  crc_engine #(
    .CRC_W(16), .POLY(CRC16_CCITT_FALSE.poly[15:0]), .INIT(CRC16_CCITT_FALSE.init[15:0]),
    .XOR_OUT(CRC16_CCITT_FALSE.xor_out[15:0]), .DATA_W(8),
    .REFLECT_IN(CRC16_CCITT_FALSE.refin), .REFLECT_OUT(CRC16_CCITT_FALSE.refout)
  ) u16 (
    .clk(clk), .arstn(arstn), .in_valid(in_valid), .in_sof(in_sof), .in_eof(in_eof),
    .in_data(in_data), .chk_en(chk_en), .crc_ref(ref16), .crc(crc16), .crc_valid(val16),
    .crc_ok(ok16), .busy(busy16), .err(err16)
  );

  crc_engine #(
    .CRC_W(32), .POLY(CRC32.poly), .INIT(CRC32.init), .XOR_OUT(CRC32.xor_out), .DATA_W(8),
    .REFLECT_IN(CRC32.refin), .REFLECT_OUT(CRC32.refout)
  ) u32a (
    .clk(clk), .arstn(arstn), .in_valid(in_valid), .in_sof(in_sof), .in_eof(in_eof),
    .in_data(in_data), .chk_en(chk_en), .crc_ref(ref32), .crc(crc32a), .crc_valid(val32a),
    .crc_ok(ok32a), .busy(busy32a), .err(err32a)
  );

  crc_engine #(
    .CRC_W(32), .POLY(CRC32.poly), .INIT(CRC32.init), .XOR_OUT(CRC32.xor_out), .DATA_W(32),
    .REFLECT_IN(CRC32.refin), .REFLECT_OUT(CRC32.refout)
  ) u32w (
    .clk(clk), .arstn(arstn), .in_valid(v_w), .in_sof(sof_w), .in_eof(eof_w),
    .in_data(data_w), .chk_en(chk_en), .crc_ref(ref32), .crc(crc32w), .crc_valid(val32w),
    .crc_ok(ok32w), .busy(busy32w), .err(err32w)
  );

  // Byte-serial reflected CRC-32 of "12345678", written the right-shifting way.
  function automatic logic [31:0] crc32_model();
    logic [31:0] c;
    logic [7:0]  b;
    c = 32'hFFFF_FFFF;
    for (int i = 0; i < 8; i++) begin
      b = 8'h31 + 8'(i);
      c = c ^ {24'h0, b};
      for (int k = 0; k < 8; k++) c = c[0] ? ((c >> 1) ^ 32'hEDB8_8320) : (c >> 1);
    end
    return ~c;
  endfunction

  task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic apply_beat(input logic s, input logic e, input logic [7:0] d);
    @(negedge clk);
    in_valid = 1'b1;
    in_sof   = s;
    in_eof   = e;
    in_data  = d;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    in_sof   = 1'b0;
    in_eof   = 1'b0;
  endtask

  task automatic apply_wide(input logic s, input logic e, input logic [31:0] d);
    @(negedge clk);
    v_w = 1'b1;
    sof_w = s;
    eof_w = e;
    data_w = d;
    @(posedge clk);
    #1;
    v_w = 1'b0;
    sof_w = 1'b0;
    eof_w = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Sends "123456789"; gap idle cycles after each non-final byte.
  task automatic send_frame(input int gap, input string tag);
    for (int i = 0; i < 9; i++) begin
      if (i == 8) begin
        check_output({tag, "_busy_before_eof"}, 32'(busy12), 32'd1);
        check_output({tag, "_novalid_before_eof"}, 32'(val12), 32'd0);
      end
      apply_beat(i == 0, i == 8, 8'h31 + 8'(i));
      if (gap > 0 && i < 8) idle(gap);
    end
  endtask

  initial begin
    #1;
    check_output("rst_crc", 32'(crc12), 32'h0);
    check_output("rst_valid_ok_busy_err", {28'h0, val12, ok12, busy12, err12}, 32'h0);
    @(negedge clk);
    arstn = 1'b1;

    // Reference check strings with idle gaps, checked on all byte-wide engines.
    chk_en = 1'b1;
    ref12 = 12'hF5B;
    ref16 = 16'h29B1;
    ref32 = 32'hCBF4_3926;
    send_frame(2, "gap");
    check_output("crc12_check", 32'(crc12), 32'hF5B);
    check_output("crc12_valid", 32'(val12), 32'd1);
    check_output("crc12_ok_match", 32'(ok12), 32'd1);
    check_output("crc16_check", 32'(crc16), 32'h29B1);
    check_output("crc16_ok", 32'(ok16), 32'd1);
    check_output("crc32_check", crc32a, 32'hCBF4_3926);
    check_output("busy_after_eof", 32'(busy12), 32'd0);
    idle(1);
    check_output("valid_one_cycle", 32'(val12), 32'd0);
    check_output("ok_drops_with_valid", 32'(ok12), 32'd0);
    check_output("crc_held", 32'(crc12), 32'hF5B);

    ref12 = 12'hF5A;
    send_frame(0, "bad_ref");
    check_output("ok_wrong_ref", 32'(ok12), 32'd0);
    check_output("crc_wrong_ref", 32'(crc12), 32'hF5B);

    chk_en = 1'b0;
    ref12 = 12'hF5B;
    send_frame(0, "nochk");
    check_output("ok_chk_off", 32'(ok12), 32'd0);
    check_output("valid_chk_off", 32'(val12), 32'd1);

    // One-word frame then a frame starting in the very next cycle.
    apply_beat(1'b1, 1'b1, 8'h00);
    check_output("single_crc", 32'(crc12), 32'h000);
    check_output("single_valid", 32'(val12), 32'd1);
    apply_beat(1'b1, 1'b0, 8'h31);
    check_output("b2b_first_beat_valid", 32'(val12), 32'd0);
    check_output("b2b_busy", 32'(busy12), 32'd1);
    for (int i = 1; i < 9; i++) apply_beat(1'b0, i == 8, 8'h31 + 8'(i));
    check_output("b2b_crc", 32'(crc12), 32'hF5B);
    check_output("b2b_valid", 32'(val12), 32'd1);

    // Words without sof while idle are dropped and flagged.
    apply_beat(1'b0, 1'b0, 8'h55);
    check_output("idle_nosof_err", 32'(err12), 32'd1);
    check_output("idle_nosof_novalid", 32'(val12), 32'd0);
    check_output("idle_nosof_busy", 32'(busy12), 32'd0);
    apply_beat(1'b0, 1'b1, 8'h39);
    check_output("idle_eof_err", 32'(err12), 32'd1);
    check_output("idle_eof_novalid", 32'(val12), 32'd0);
    idle(1);
    check_output("err_one_cycle", 32'(err12), 32'd0);

    // A sof mid-frame restarts from INIT.
    apply_beat(1'b1, 1'b0, 8'hAA);
    apply_beat(1'b0, 1'b0, 8'hBB);
    check_output("prefix_no_err", 32'(err12), 32'd0);
    apply_beat(1'b1, 1'b0, 8'h31);
    check_output("restart_err", 32'(err12), 32'd1);
    check_output("restart_busy", 32'(busy12), 32'd1);
    for (int i = 1; i < 9; i++) apply_beat(1'b0, i == 8, 8'h31 + 8'(i));
    check_output("restart_crc", 32'(crc12), 32'hF5B);
    check_output("restart_err_clear", 32'(err12), 32'd0);

    // Reset mid-frame aborts it.
    apply_beat(1'b1, 1'b0, 8'h31);
    apply_beat(1'b0, 1'b0, 8'h32);
    arstn = 1'b0;
    #1;
    check_output("midrst_crc", 32'(crc12), 32'h0);
    check_output("midrst_flags", {28'h0, val12, ok12, busy12, err12}, 32'h0);
    @(negedge clk);
    arstn = 1'b1;
    apply_beat(1'b0, 1'b1, 8'h39);
    check_output("after_rst_novalid", 32'(val12), 32'd0);
    check_output("after_rst_err", 32'(err12), 32'd1);
    check_output("after_rst_crc", 32'(crc12), 32'h0);

    // CRC-32 with 32-bit words packed little-endian.
    apply_wide(1'b1, 1'b0, 32'h3433_3231);
    check_output("wide_busy", 32'(busy32w), 32'd1);
    apply_wide(1'b0, 1'b1, 32'h3837_3635);
    check_output("wide_crc", crc32w, crc32_model());
    check_output("wide_valid", 32'(val32w), 32'd1);
    idle(1);
    check_output("wide_valid_pulse", 32'(val32w), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
